// File: rtl/seq_det_pkg.sv
// ============================================================================
// seq_det_pkg : shared mode constants and pattern-width limits
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear and increment on the same edge land on 1, not 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
// seq_detect_param : configurable serial pattern detector with match counter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int             PAT_W       = 4,
    parameter int             CNT_W       = 8,
    parameter bit             OVERLAP_DEF = 1'b1,
    parameter logic [PAT_W-1:0] PAT_DEF   = 4'b1010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clear,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);
    generate
        if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
            $error("seq_detect_param: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
        end
    endgenerate

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_next;
    logic [PAT_W-1:0]  hist_next;
    logic              match;

    always_comb begin
        hist_shift = {hist[PAT_W-2:0], in};
        fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        match      = 1'b0;
        hist_next  = hist;
        fill_next  = fill;
        if (cfg_load) begin
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            match     = (hist_shift == pattern) && (fill_inc == FILL_FULL);
            hist_next = hist_shift;
            // Non-overlap restarts the window so no matched bit is reused.
            fill_next = (match && (overlap == MODE_NONOVL)) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern <= PAT_DEF;
            overlap <= OVERLAP_DEF;
            hist    <= '0;
            fill    <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (cfg_load) begin
                pattern <= cfg_pattern;
                overlap <= cfg_overlap;
            end
            hist <= hist_next;
            fill <= fill_next;
            out  <= match;
            busy <= (fill_next != '0);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (match),
        .count (match_cnt)
    );
endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL take parameter PAT_W, default 4, which sets the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL take parameter CNT_W, default 8, which sets the match counter width in bits.
REQ-003 The block SHALL take parameter OVERLAP_DEF, default 1, which sets the mode after reset (1 overlap, 0 non-overlap).
REQ-004 The block SHALL take parameter PAT_DEF, default 4'b1010 (PAT_W bits), which is the pattern loaded at reset.
REQ-005 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-006 Port list:
  - clk  input  1  rising-edge clock.
  - reset  input  1  synchronous, active-low reset.
  - in  input  1  serial data bit.
  - in_valid  input  1  qualifies in; the bit is sampled only when high.
  - cfg_load  input  1  one-cycle strobe that loads cfg_pattern and cfg_overlap.
  - cfg_pattern  input  PAT_W  new pattern, MSB = first bit received.
  - cfg_overlap  input  1  new mode.
  - cnt_clear  input  1  synchronous clear of match_cnt.
  - out  output  1  Moore match flag.
  - match_cnt  output  CNT_W  saturating count of matches.
  - busy  output  1  high while history holds at least 1 valid bit.

Function
REQ-007 The block SHALL hold the following registers: pattern (PAT_W), overlap (1), history shift register hist (PAT_W), fill counter fill (0..PAT_W), out, and match_cnt.
REQ-008 On each clk edge with in_valid=1 and cfg_load=0, the block SHALL shift hist left with in entering the LSB, and SHALL increment fill, saturating at PAT_W.
REQ-009 A match event SHALL be declared when the post-shift hist equals pattern and the post-shift fill equals PAT_W.
REQ-010 out SHALL be registered (Moore): high for exactly the one cycle following the edge that sampled the final pattern bit, and low otherwise.
REQ-011 Cycles with in_valid=0 SHALL leave hist and fill unchanged, and out SHALL go low on that edge.
REQ-012 In overlap mode, a match SHALL leave hist and fill intact, so a trailing prefix can complete the next match.
REQ-013 In non-overlap mode, a match SHALL force fill to 0 on the same edge, so no bit of a matched window is reused.
REQ-014 On each match event, match_cnt SHALL increment by 1 and SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-015 cnt_clear=1 SHALL set match_cnt to 0; if cnt_clear and a match occur on the same edge, match_cnt SHALL become 1.
REQ-016 cfg_load=1 SHALL load pattern and overlap, set fill to 0 and hist to 0, and set out to 0; any in_valid bit on that edge SHALL be discarded.
REQ-017 cfg_load SHALL NOT affect match_cnt.
REQ-018 busy SHALL equal (fill != 0), registered.

Reset
REQ-019 When reset=0 at a clk edge, the block SHALL set: pattern=PAT_DEF, overlap=OVERLAP_DEF, hist=0, fill=0, out=0, match_cnt=0, busy=0.
REQ-020 Reset SHALL take priority over cfg_load, cnt_clear and in_valid, including when asserted mid-pattern; partial history SHALL be lost.
REQ-021 After reset deasserts, the first in_valid bit SHALL be treated as bit 1 of a new window.

Structure
REQ-022 A shared package seq_det_pkg SHALL hold the mode constants MODE_NONOVL=0 and MODE_OVL=1 and the PAT_W legal-range limits.
REQ-023 The saturating counter with synchronous clear SHALL be a separate sub-module sat_counter, parametrised by CNT_W.
REQ-024 An illegal PAT_W SHALL cause an elaboration-time error.

Verification
REQ-025 With PAT_W=4, pattern 1010, overlap=1, the bench SHALL drive stream 1,0,1,0,1,0,1 with in_valid=1 every cycle and SHALL see out high after bits 4 and 6 only, and match_cnt=2.
REQ-026 With the same stream and overlap=0, the bench SHALL see out high after bit 4 only, and match_cnt=1.
REQ-027 The bench SHALL drive bits 1,0 then in_valid=0 for 3 cycles then 1,0, and SHALL see a single match after the final 0 and out low during the gap.
REQ-028 The bench SHALL drive 1,0,1, then reset=0 for 1 cycle, then 0, and SHALL see no match, and fill=1 after the 0.
REQ-029 The bench SHALL use cfg_load with pattern 0110 and, on the same edge, in_valid=1 with in=0, then drive 1,1,0, and SHALL see no match; a further 0,1,1,0 SHALL give exactly 1 match.
REQ-030 With CNT_W=2 and 5 overlapping matches, match_cnt SHALL hold at 3; asserting cnt_clear on the same edge as a match SHALL give match_cnt=1.
